rom_loader: RTL and testbench
=============================

# rom_loader

Boot-time writer for the instruction ROM's write port (`we_i`/`addr_i`/`data_i`). It accepts a byte stream from a UART receiver or debug bridge and assembles little-endian 32-bit words. It writes each word sequentially from ROM word 0 and holds the core off while the load is in progress. It sits between the byte source and the ROM; the core fetches from the ROM only after `done_o`.

## Interface
- `DEPTH_WORDS`, default 512: ROM capacity in words; the maximum legal word count.
- `ADDR_W`, default 32: width of `rom_addr_o`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  single-cycle pulse that opens a load session.
- `byte_valid_i`  in  1  byte source has data.
- `byte_i`  in  8  stream byte.
- `byte_ready_o`  out  1  loader accepts `byte_i` this cycle.
- `rom_we_o`  out  1  ROM write enable, one cycle per word.
- `rom_addr_o`  out  ADDR_W  byte address of the word (word index << 2).
- `rom_data_o`  out  32  assembled word.
- `busy_o`  out  1  session active.
- `hold_o`  out  1  core hold; equals `busy_o`.
- `done_o`  out  1  level; load completed successfully.
- `err_o`  out  1  level; load aborted.

## Operation
- **Stream format:** LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes, LSB first per word. The checksum byte follows only when the checksum feature is compiled in.
- **Byte transfer:** a byte is consumed when `byte_valid_i && byte_ready_o`. `byte_i` is ignored otherwise.
- **FSM states:** IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR.
- **IDLE:** on `start_i`, go to LEN_LO. This clears `done_o`/`err_o`, zeros the word index and byte counter, and sets `busy_o`.
- **LEN_LO → LEN_HI:** on consume.
- **LEN_HI:** on consume, latch N. If N==0 or N>DEPTH_WORDS, go to ERR with no ROM writes; otherwise go to DATA.
- **DATA:**
  - Shift the consumed byte into bits [8k+7:8k], where k is a 2-bit byte counter.
  - When the 4th byte is consumed, go to WRITE.
- **WRITE:** lasts one cycle.
  - `rom_we_o`=1, with `rom_addr_o`={idx,2'b00} and `rom_data_o`=the assembled word.
  - Then idx increments.
  - If idx was N−1, go to CSUM (feature on) or DONE; else return to DATA.
- **DONE:** `busy_o`/`hold_o`=0 and `done_o`=1 until the next `start_i` or `rst`.
- **ERR:** `busy_o`/`hold_o`=0 and `err_o`=1 until the next `start_i` or `rst`. No further bytes are consumed.
- **`start_i` while busy:** ignored.
- **`start_i` in DONE/ERR:** starts a new session, identical to starting from IDLE.
- **Index range:** idx never exceeds DEPTH_WORDS−1, so there is no address wrap.
- **Reset mid-session:** returns to IDLE. ROM words already written stay written, and a partial word is discarded.

## Timing
- **Reset values:**
  - `byte_ready_o`, `rom_we_o`, `busy_o`, `hold_o`, `done_o`, `err_o` = 0.
  - `rom_addr_o` = 0, `rom_data_o` = 0.
- **`busy_o` rise:** the cycle after `start_i`. `byte_ready_o` is high in LEN_LO, LEN_HI, DATA and CSUM, so it is first high the cycle after `start_i`.
- **`byte_ready_o` is registered:** it is low in WRITE, giving one bubble per word. With continuous `byte_valid_i`, each word takes 5 cycles.
- **ROM write latency:** `rom_we_o` is high in the cycle after the 4th byte of a word is consumed. `rom_addr_o`/`rom_data_o` are stable in that cycle and hold their values afterwards.
- **`done_o` rise:** the cycle after the last WRITE (or after the checksum byte is consumed). `busy_o` falls in the same cycle.
- **`err_o` rise:** the cycle after the offending LEN_HI byte or checksum byte.
- **Minimum session length:** 2 + 5·N cycles after `busy_o` rises (+1 with checksum).

## Configuration
- **`ROM_LOADER_CHECKSUM_EN` defined:**
  - A running XOR covers every payload byte (the length bytes are excluded) and resets on `start_i`.
  - After the last WRITE the FSM enters CSUM and consumes one byte.
  - If that byte equals the running XOR, go to DONE; otherwise go to ERR. Words already written are not rolled back.
- **Undefined:** there is no CSUM state or XOR register, and the FSM goes WRITE → DONE directly.

## Structure
- **`rom_loader_pkg`:**
  - State encoding localparams for IDLE…ERR (3 bits).
  - `LEN_W`=16 and `BYTES_PER_WORD`=4.
- **`rom_loader_word_asm`:** the natural sub-module. It is a 4-byte shift/assemble register with a 2-bit counter and a `word_ready` strobe; the FSM in `rom_loader` drives it.

## Test plan
- **Reset during load:** after the 1st word is written, assert `rst` mid-way through the 2nd word. Required: all outputs return to reset values, and after a new `start_i` the 2nd word is rewritten correctly.
- **Single word:** `start_i`; stream 01 00 78 56 34 12. Required: one `rom_we_o` pulse with addr 0x0 and data 0x12345678, then `done_o`=1 the following cycle.
- **Back-to-back words:** N=3 with continuous valid. Required: writes to 0x0, 0x4, 0x8; exactly 5 cycles between `rom_we_o` pulses; `hold_o` high from the cycle after `start_i` until `done_o`.
- **Bad length:** N=0, then a new session with N=513 (01 02). Required: `err_o`=1, no `rom_we_o`, and `byte_ready_o` low afterwards.
- **Back-pressure:** toggle `byte_valid_i` randomly; `start_i` during busy. Required: data identical to the gapless case, and the session is unaffected by the stray `start_i`.
- **Checksum (`ROM_LOADER_CHECKSUM_EN`):** payload 78 56 34 12, checksum 0x08. Required: `done_o`. Repeat with checksum 0x09. Required: `err_o`=1, with the word still written.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared constants, state encoding and small helpers for the rom_loader boot writer.
package rom_loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_CSUM   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LEN_LO = ST_LEN_LO,
    S_LEN_HI = ST_LEN_HI,
    S_DATA   = ST_DATA,
    S_WRITE  = ST_WRITE,
    S_CSUM   = ST_CSUM,
    S_DONE   = ST_DONE,
    S_ERR    = ST_ERR
  } state_t;

  function automatic logic [LEN_W-1:0] join_len(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

  function automatic logic accepts_bytes(input state_t s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s != S_IDLE) && (s != S_DONE) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream handshake and ROM write-port bundle between the loader and its neighbours.
interface rom_loader_if #(
  parameter int ADDR_W = 32
);
  logic              byte_valid_i;
  logic [7:0]        byte_i;
  logic              byte_ready_o;
  logic              rom_we_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [31:0]       rom_data_o;

  modport master (
    input  byte_valid_i, byte_i,
    output byte_ready_o, rom_we_o, rom_addr_o, rom_data_o
  );

  modport slave (
    output byte_valid_i, byte_i,
    input  byte_ready_o, rom_we_o, rom_addr_o, rom_data_o
  );
endinterface

// File: rtl/rom_loader_word_asm.sv
// Little-endian word assembler: bytes land in lane cnt, word_ready flags the 4th byte.
module rom_loader_word_asm
  import rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [31:0] word_next,
  output logic        word_ready
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_r;
  logic [31:0] word_r;

  // Splice the incoming byte into the current lane without disturbing the others
  always_comb begin
    word_next = word_r;
    case (cnt_r)
      2'd0:    word_next[7:0]   = din;
      2'd1:    word_next[15:8]  = din;
      2'd2:    word_next[23:16] = din;
      2'd3:    word_next[31:24] = din;
      default: word_next        = word_r;
    endcase
  end

  assign word_ready = shift_en && (cnt_r == LAST_LANE);

  // Lane counter and partial word; the counter wraps to lane 0 after each full word
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r  <= 2'd0;
      word_r <= 32'h0000_0000;
    end else if (shift_en) begin
      cnt_r  <= cnt_r + 2'd1;
      word_r <= word_next;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Boot-time ROM loader: length header, little-endian words written from word 0.
// Optional trailing XOR checksum byte when ROM_LOADER_CHECKSUM_EN is defined.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int ADDR_W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  rom_loader_if.master bus,
  output logic         busy_o,
  output logic         hold_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int             IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH_WORDS);

  state_t            state_r, next_state_s;
  logic [7:0]        len_lo_r;
  logic [LEN_W-1:0]  len_r, len_next_s;
  logic [IDX_W-1:0]  idx_r;
  logic              ready_r, we_r, busy_r, done_r, err_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       data_r, word_next_s;
  logic              consume_s, start_s, shift_s, word_ready_s, last_s, len_bad_s;

  assign consume_s  = bus.byte_valid_i && ready_r;
  assign start_s    = start_i && !is_busy(state_r);
  assign shift_s    = consume_s && (state_r == S_DATA);
  assign len_next_s = join_len(len_lo_r, bus.byte_i);
  assign len_bad_s  = (len_next_s == {LEN_W{1'b0}}) || ({1'b0, len_next_s} > DEPTH_L);
  assign last_s     = (LEN_W'(idx_r) == (len_r - 16'd1));

  rom_loader_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_s),
    .shift_en   (shift_s),
    .din        (bus.byte_i),
    .word_next  (word_next_s),
    .word_ready (word_ready_s)
  );

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] csum_r;
  logic       csum_ok_s;

  assign csum_ok_s = (bus.byte_i == csum_r);

  // Running XOR over payload bytes only; the length header is excluded
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      csum_r <= 8'h00;
    end else if (shift_s) begin
      csum_r <= csum_r ^ bus.byte_i;
    end
  end
`endif

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_s) next_state_s = S_LEN_LO;
        else         next_state_s = state_r;
      end
      S_LEN_LO: begin
        if (consume_s) next_state_s = S_LEN_HI;
        else           next_state_s = S_LEN_LO;
      end
      S_LEN_HI: begin
        if (consume_s) next_state_s = len_bad_s ? S_ERR : S_DATA;
        else           next_state_s = S_LEN_HI;
      end
      S_DATA: begin
        if (word_ready_s) next_state_s = S_WRITE;
        else              next_state_s = S_DATA;
      end
      S_WRITE: begin
        if (last_s) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          next_state_s = S_CSUM;
`else
          next_state_s = S_DONE;
`endif
        end else begin
          next_state_s = S_DATA;
        end
      end
      S_CSUM: begin
`ifdef ROM_LOADER_CHECKSUM_EN
        if (consume_s) next_state_s = csum_ok_s ? S_DONE : S_ERR;
        else           next_state_s = S_CSUM;
`else
        next_state_s = S_ERR;
`endif
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; status flags are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      len_lo_r <= 8'h00;
      len_r    <= {LEN_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      ready_r  <= 1'b0;
      we_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      data_r   <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      ready_r <= accepts_bytes(next_state_s);
      busy_r  <= is_busy(next_state_s);
      done_r  <= (next_state_s == S_DONE);
      err_r   <= (next_state_s == S_ERR);
      we_r    <= word_ready_s;
      if (word_ready_s) begin
        addr_r <= ADDR_W'({idx_r, 2'b00});
        data_r <= word_next_s;
      end
      if (state_r == S_LEN_LO && consume_s) len_lo_r <= bus.byte_i;
      if (state_r == S_LEN_HI && consume_s) len_r <= len_next_s;
      // idx stops at N-1 so it never leaves the ROM range
      if (start_s) begin
        idx_r <= {IDX_W{1'b0}};
      end else if (state_r == S_WRITE && !last_s) begin
        idx_r <= idx_r + IDX_W'(1'b1);
      end
    end
  end

  assign bus.byte_ready_o = ready_r;
  assign bus.rom_we_o     = we_r;
  assign bus.rom_addr_o   = addr_r;
  assign bus.rom_data_o   = data_r;
  assign busy_o           = busy_r;
  assign hold_o           = busy_r;
  assign done_o           = done_r;
  assign err_o            = err_r;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: randomized streams against a queue-based stream/ROM model.
module tb_rom_loader;

  localparam int DEPTH = 512;
  localparam int AW    = 32;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic busy_o, hold_o, done_o, err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_cnt = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            wc_q[$];
  logic [31:0]   shadow[DEPTH];

  rom_loader_if #(.ADDR_W(AW)) bus ();

  rom_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .bus(bus),
    .busy_o(busy_o), .hold_o(hold_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM-side observer: records every write and models the ROM contents
  always @(negedge clk) begin
    if (bus.rom_we_o === 1'b1) begin
      wa_q.push_back(bus.rom_addr_o);
      wd_q.push_back(bus.rom_data_o);
      wc_q.push_back(cyc);
      shadow[bus.rom_addr_o[10:2]] <= bus.rom_data_o;
    end
    if (hold_o === 1'b1) hold_cnt <= hold_cnt + 1;
  end

  function automatic wq_t rand_words(input int n);
    wq_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return w;
  endfunction

  // Stream model: LE length, LE payload words, optional XOR of payload bytes
  function automatic bq_t build_stream(input wq_t w);
    bq_t q;
    logic [15:0] n;
    n = 16'(w.size());
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    foreach (w[i]) for (int b = 0; b < 4; b++) q.push_back(8'(w[i] >> (8 * b)));
`ifdef ROM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int j = 2; j < q.size(); j++) x = x ^ q[j];
      q.push_back(x);
    end
`endif
    return q;
  endfunction

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic drive_bytes(input bq_t q, input bit gaps, input bit stray, output int got);
    int guard;
    guard = 0;
    got = 0;
    while (got < q.size() && guard < 6000) begin
      bus.byte_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.byte_i       = bus.byte_valid_i ? q[got] : 8'($urandom);
      start_i          = stray && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (bus.byte_valid_i && bus.byte_ready_o) got++;
      @(posedge clk); #1;
      guard++;
    end
    bus.byte_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic wait_end(output int ce, output bit to, output logic bz);
    to = 1'b1;
    ce = 0;
    bz = 1'bx;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_o === 1'b1 || err_o === 1'b1) begin
        to = 1'b0;
        ce = cyc;
        bz = busy_o | hold_o;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] ov[8];
    string nm[8];
    ov = '{32'(bus.byte_ready_o), 32'(bus.rom_we_o), 32'(busy_o), 32'(hold_o),
           32'(done_o), 32'(err_o), 32'(bus.rom_addr_o), bus.rom_data_o};
    nm = '{"ready", "we", "busy", "hold", "done", "err", "addr", "data"};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ov[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_%s: got %h required 0", nm[i], ov[i]);
      end
    end
  endtask

  task automatic test_single();
    bq_t q;
    int n0, ce, got;
    bit to;
    logic bz;
    n0 = wd_q.size();
    do_start();
    checks++;
    if (busy_o !== 1'b1 || bus.byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_rise: busy=%b ready=%b required 1 1", busy_o, bus.byte_ready_o);
    end
    q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef ROM_LOADER_CHECKSUM_EN
    q.push_back(8'h08);
`endif
    drive_bytes(q, 1'b0, 1'b0, got);
    checks++;
    if (got != q.size()) begin errors++; $display("FAIL single_bytes: got %0d required %0d", got, q.size()); end
    wait_end(ce, to, bz);
    checks++;
    if (to || done_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b err=%b timeout=%b required 1 0 0", done_o, err_o, to);
    end
    checks++;
    if (bz !== 1'b0) begin errors++; $display("FAIL single_busy_fall: busy|hold=%b required 0", bz); end
    checks++;
    if (wd_q.size() != n0 + 1) begin errors++; $display("FAIL single_wr_count: got %0d required 1", wd_q.size() - n0); end
    if (wd_q.size() > n0) begin
      checks++;
      if (wa_q[n0] !== 32'h0) begin errors++; $display("FAIL single_addr: got %h required 0", wa_q[n0]); end
      checks++;
      if (wd_q[n0] !== 32'h1234_5678) begin errors++; $display("FAIL single_data: got %h required 12345678", wd_q[n0]); end
`ifndef ROM_LOADER_CHECKSUM_EN
      checks++;
      if (ce != wc_q[n0] + 1) begin errors++; $display("FAIL single_done_lat: got %0d required %0d", ce - wc_q[n0], 1); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    wq_t w;
    bq_t q;
    int n0, h0, ce, got;
    bit to;
    logic bz;
    w = rand_words(3);
    q = build_stream(w);
    n0 = wd_q.size();
    h0 = hold_cnt;
    do_start();
    drive_bytes(q, 1'b0, 1'b0, got);
    wait_end(ce, to, bz);
    checks++;
    if (to || done_o !== 1'b1 || bz !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%b busy=%b timeout=%b required 1 0 0", done_o, bz, to);
    end
    checks++;
    if (wd_q.size() != n0 + 3) begin errors++; $display("FAIL b2b_wr_count: got %0d required 3", wd_q.size() - n0); end
    if (wd_q.size() == n0 + 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa_q[n0+i] !== 32'(4 * i) || wd_q[n0+i] !== w[i]) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h@%h required %h@%h", i, wd_q[n0+i], wa_q[n0+i], w[i], 32'(4 * i));
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (wc_q[n0+i] - wc_q[n0+i-1] != 5) begin
          errors++;
          $display("FAIL b2b_spacing%0d: got %0d required 5", i, wc_q[n0+i] - wc_q[n0+i-1]);
        end
      end
    end
    checks++;
    if (hold_cnt - h0 != 2 + 5 * 3 + CS) begin
      errors++;
      $display("FAIL b2b_hold_cycles: got %0d required %0d", hold_cnt - h0, 2 + 5 * 3 + CS);
    end
  endtask

  task automatic test_bad_len();
    int lens[2];
    bq_t q;
    int n0, ce, got;
    bit to;
    logic bz;
    lens = '{0, DEPTH + 1};
    for (int t = 0; t < 2; t++) begin
      n0 = wd_q.size();
      do_start();
      q = '{8'(lens[t]), 8'(lens[t] >> 8)};
      drive_bytes(q, 1'b0, 1'b0, got);
      wait_end(ce, to, bz);
      checks++;
      if (to || err_o !== 1'b1 || done_o !== 1'b0 || bz !== 1'b0) begin
        errors++;
        $display("FAIL badlen%0d_err: err=%b done=%b busy=%b timeout=%b required 1 0 0 0", lens[t], err_o, done_o, bz, to);
      end
      for (int k = 0; k < 4; k++) begin
        bus.byte_valid_i = 1'b1;
        bus.byte_i = 8'($urandom);
        @(negedge clk);
        checks++;
        if (bus.byte_ready_o !== 1'b0) begin errors++; $display("FAIL badlen%0d_ready: got %b required 0", lens[t], bus.byte_ready_o); end
        @(posedge clk); #1;
      end
      bus.byte_valid_i = 1'b0;
      checks++;
      if (wd_q.size() != n0 || err_o !== 1'b1) begin
        errors++;
        $display("FAIL badlen%0d_nowrite: writes=%0d err=%b required 0 1", lens[t], wd_q.size() - n0, err_o);
      end
    end
  endtask

  task automatic test_backpressure();
    wq_t w;
    bq_t q;
    int n0, ce, got, n, bad;
    bit to;
    logic bz;
    n = $urandom_range(2, 6);
    w = rand_words(n);
    q = build_stream(w);
    n0 = wd_q.size();
    do_start();
    drive_bytes(q, 1'b1, 1'b1, got);
    wait_end(ce, to, bz);
    checks++;
    if (to || done_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done=%b err=%b timeout=%b required 1 0 0", done_o, err_o, to);
    end
    checks++;
    if (wd_q.size() != n0 + n) begin errors++; $display("FAIL bp_wr_count: got %0d required %0d", wd_q.size() - n0, n); end
    bad = 0;
    for (int i = 0; i < n && n0 + i < wd_q.size(); i++)
      if (wa_q[n0+i] !== 32'(4 * i) || wd_q[n0+i] !== w[i] || shadow[i] !== w[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_words: got %0d bad words required 0", bad); end
  endtask

  task automatic test_max_len();
    wq_t w;
    bq_t q;
    int n0, ce, got, bad;
    bit to;
    logic bz;
    w = rand_words(DEPTH);
    q = build_stream(w);
    n0 = wd_q.size();
    do_start();
    drive_bytes(q, 1'b0, 1'b0, got);
    wait_end(ce, to, bz);
    checks++;
    if (to || done_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL max_done: done=%b err=%b timeout=%b required 1 0 0", done_o, err_o, to);
    end
    checks++;
    if (wd_q.size() != n0 + DEPTH) begin errors++; $display("FAIL max_wr_count: got %0d required %0d", wd_q.size() - n0, DEPTH); end
    bad = 0;
    for (int i = 0; i < DEPTH && n0 + i < wd_q.size(); i++)
      if (wa_q[n0+i] !== 32'(4 * i) || wd_q[n0+i] !== w[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL max_words: got %0d bad words required 0", bad); end
    checks++;
    if (wa_q[wa_q.size()-1] !== 32'h0000_07FC) begin
      errors++;
      $display("FAIL max_last_addr: got %h required 000007fc", wa_q[wa_q.size()-1]);
    end
  endtask

  task automatic test_reset_mid();
    wq_t w;
    bq_t q, part;
    int n0, n1, ce, got;
    bit to;
    logic bz;
    logic [31:0] ov[8];
    string nm[8];
    w = rand_words(2);
    q = build_stream(w);
    part = q[0:7];
    n0 = wd_q.size();
    do_start();
    drive_bytes(part, 1'b0, 1'b0, got);
    checks++;
    if (wd_q.size() != n0 + 1) begin errors++; $display("FAIL rmid_first_write: got %0d required 1", wd_q.size() - n0); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ov = '{32'(bus.byte_ready_o), 32'(bus.rom_we_o), 32'(busy_o), 32'(hold_o),
           32'(done_o), 32'(err_o), 32'(bus.rom_addr_o), bus.rom_data_o};
    nm = '{"ready", "we", "busy", "hold", "done", "err", "addr", "data"};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ov[i] !== 32'h0) begin errors++; $display("FAIL rmid_reset_%s: got %h required 0", nm[i], ov[i]); end
    end
    n1 = wd_q.size();
    do_start();
    drive_bytes(q, 1'b0, 1'b0, got);
    wait_end(ce, to, bz);
    checks++;
    if (to || done_o !== 1'b1) begin errors++; $display("FAIL rmid_done: done=%b timeout=%b required 1 0", done_o, to); end
    checks++;
    if (wd_q.size() != n1 + 2) begin errors++; $display("FAIL rmid_wr_count: got %0d required 2", wd_q.size() - n1); end
    checks++;
    if (shadow[0] !== w[0] || shadow[1] !== w[1]) begin
      errors++;
      $display("FAIL rmid_rom: got %h %h required %h %h", shadow[0], shadow[1], w[0], w[1]);
    end
  endtask

`ifdef ROM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] cs[2];
    bq_t q;
    int n0, ce, got;
    bit to;
    logic bz;
    cs = '{8'h08, 8'h09};
    for (int t = 0; t < 2; t++) begin
      n0 = wd_q.size();
      do_start();
      q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, cs[t]};
      drive_bytes(q, 1'b0, 1'b0, got);
      wait_end(ce, to, bz);
      checks++;
      if (to || done_o !== (t == 0) || err_o !== (t == 1)) begin
        errors++;
        $display("FAIL csum%0d_status: done=%b err=%b timeout=%b required %b %b 0", t, done_o, err_o, to, t == 0, t == 1);
      end
      checks++;
      if (wd_q.size() != n0 + 1 || wd_q[wd_q.size()-1] !== 32'h1234_5678) begin
        errors++;
        $display("FAIL csum%0d_word: writes=%0d last=%h required 1 12345678", t, wd_q.size() - n0, wd_q[wd_q.size()-1]);
      end
    end
  endtask
`endif

  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_single();
    test_back_to_back();
    test_bad_len();
    test_backpressure();
    test_max_len();
    test_reset_mid();
`ifdef ROM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
